// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default memory geometry
// and the loader state encoding, so the memory and the loader agree.
package imem_loader_pkg;

    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream. The completing byte is
// passed straight through so the word is available in the cycle it arrives.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_complete
);

    logic [1:0]  idx_q;
    logic [23:0] shreg_q;

    // The 4th byte never needs storing: the top registers the full word on its arrival.
    assign word_out      = {shreg_q, byte_in};
    assign word_complete = shift_en && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (shift_en) begin
            idx_q   <= idx_q + 2'd1;
            shreg_q <= {shreg_q[15:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame loader: count byte, 4*N big-endian data bytes, XOR checksum byte.
// Writes instruction memory and holds the core in reset until a verified image is resident.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output loader_state_e     state_dbg
);

    // Handshake: a byte moves on a cycle where rx_valid && rx_ready; rx_ready is
    // registered and high only in COUNT/DATA/CHECK, and bytes never get dropped.
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    loader_state_e   state_q, state_d;
    logic [ADDR_W:0] n_q;
    logic [7:0]      xor_q;
    logic            fire;
    logic            count_bad;
    logic            last_word;
    logic            pk_clear;
    logic            pk_shift;
    logic            pk_complete;
    logic [31:0]     pk_word;

    assign fire      = rx_valid && rx_ready;
    assign count_bad = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH_LIM);
    assign last_word = ((words_loaded + 1'b1) == n_q);
    assign pk_shift  = (state_q == ST_DATA) && fire;
    assign pk_clear  = (state_q == ST_COUNT) && fire;
    assign state_dbg = state_q;

    byte_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (pk_clear),
        .shift_en      (pk_shift),
        .byte_in       (rx_data),
        .word_out      (pk_word),
        .word_complete (pk_complete)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_COUNT;
            ST_COUNT: if (fire) state_d = count_bad ? ST_ERR : ST_DATA;
            ST_DATA:  if (pk_complete && last_word) state_d = ST_CHECK;
            ST_CHECK: if (fire) state_d = (rx_data == xor_q) ? ST_DONE : ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            core_reset   <= 1'b1;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            n_q          <= '0;
            xor_q        <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready   <= (state_d == ST_COUNT) || (state_d == ST_DATA) || (state_d == ST_CHECK);
            busy       <= (state_d == ST_COUNT) || (state_d == ST_DATA) || (state_d == ST_CHECK);
            done       <= (state_d == ST_DONE);
            error      <= (state_d == ST_ERR);
            core_reset <= (state_d != ST_DONE);
            imem_we    <= pk_complete;

            if (pk_complete) begin
                imem_waddr   <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= pk_word;
                words_loaded <= words_loaded + 1'b1;
            end

            if ((state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR) && start) begin
                words_loaded <= '0;
            end

            // The checksum covers the count byte, so the running XOR starts from it.
            if (pk_clear && !count_bad) begin
                n_q          <= rx_data[ADDR_W:0];
                xor_q        <= rx_data;
                words_loaded <= '0;
            end

            if (pk_shift) begin
                xor_q <= xor_q ^ rx_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus random frames checked against a
// frame-level model that decodes the byte stream independently of the RTL.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, imem_we, core_reset, busy, done, error;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;
    loader_state_e     state_dbg;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W+31:0] wr_q[$];
    logic [31:0]        exp_q[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_reset(core_reset),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_waddr, imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        check("rx_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic build_frame(input int n, input bit bad_ck, output logic [7:0] fr[$]);
        logic [7:0]  ck;
        logic [31:0] w;
        fr.delete();
        fr.push_back(8'(n));
        ck = 8'(n);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int k = 3; k >= 0; k--) begin
                fr.push_back(w[8*k +: 8]);
                ck ^= w[8*k +: 8];
            end
        end
        fr.push_back(bad_ck ? (ck ^ 8'(1 << $urandom_range(0, 7))) : ck);
    endtask

    // Frame-level reference: decode count, words and checksum straight from the bytes.
    task automatic load_and_check(input logic [7:0] fr[$], input bit gaps, input string tag);
        int         n;
        bit         cnt_ok, ck_ok;
        logic [7:0] ck;
        n      = int'(fr[0]);
        cnt_ok = (n >= 1) && (n <= DEPTH);
        exp_q.delete();
        wr_q.delete();
        ck = fr[0];
        if (cnt_ok) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({fr[4*i+1], fr[4*i+2], fr[4*i+3], fr[4*i+4]});
            for (int i = 1; i <= 4*n; i++) ck ^= fr[i];
        end
        ck_ok = cnt_ok && (ck == fr[4*n+1]);

        pulse_start();
        check({tag, "_core_reset_start"}, {63'd0, core_reset}, 64'd1);
        if (cnt_ok) begin
            for (int i = 0; i <= 4*n + 1; i++) send_byte(fr[i], gaps);
        end else begin
            send_byte(fr[0], gaps);
        end
        check({tag, "_done"},       {63'd0, done},       {63'd0, ck_ok});
        check({tag, "_error"},      {63'd0, error},      {63'd0, !ck_ok});
        check({tag, "_core_reset"}, {63'd0, core_reset}, {63'd0, !ck_ok});
        check({tag, "_busy"},       {63'd0, busy},       64'd0);
        check({tag, "_words"},      64'(words_loaded),   64'(cnt_ok ? n : 0));
        check({tag, "_nwrites"},    64'(wr_q.size()),    64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({tag, "_write"}, 64'(wr_q[i]), 64'({6'(i), exp_q[i]}));
    endtask

    initial begin
        logic [7:0] fr[$];
        int         n;

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        check("rst_state",      64'(state_dbg),    64'(ST_IDLE));
        check("rst_rx_ready",   {63'd0, rx_ready}, 64'd0);
        check("rst_imem_we",    {63'd0, imem_we},  64'd0);
        check("rst_waddr",      64'(imem_waddr),   64'd0);
        check("rst_wdata",      64'(imem_wdata),   64'd0);
        check("rst_core_reset", {63'd0, core_reset}, 64'd1);
        check("rst_flags",      {61'd0, busy, done, error}, 64'd0);
        check("rst_words",      64'(words_loaded), 64'd0);
        reset = 1'b0;
        tick();

        // Bytes offered in IDLE are not consumed.
        rx_valid = 1'b1; rx_data = 8'h5A;
        repeat (3) tick();
        check("idle_no_accept", {63'd0, rx_ready}, 64'd0);
        check("idle_state",     64'(state_dbg),    64'(ST_IDLE));
        rx_valid = 1'b0;

        // Two-word frame; XOR of count and data bytes is 0xAA.
        fr = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00, 8'hAA};
        load_and_check(fr, 1'b0, "two_word");
        check("two_word_addr0", 64'(wr_q[0]), 64'({6'd0, 32'h20080005}));
        check("two_word_addr1", 64'(wr_q[1]), 64'({6'd1, 32'h8C090000}));

        fr = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00, 8'hAB};
        load_and_check(fr, 1'b0, "bad_ck");

        // Bytes offered in ERR are not consumed.
        rx_valid = 1'b1; rx_data = 8'h33;
        repeat (3) tick();
        check("err_hold", 64'(state_dbg), 64'(ST_ERR));
        rx_valid = 1'b0;

        fr = '{8'h00};
        load_and_check(fr, 1'b0, "count_zero");
        fr = '{8'h41};
        load_and_check(fr, 1'b0, "count_65");

        build_frame(64, 1'b0, fr);
        load_and_check(fr, 1'b1, "full64");

        for (int t = 0; t < 8; t++) begin
            n = (t == 5) ? $urandom_range(65, 255) : $urandom_range(1, 12);
            build_frame(n, ($urandom_range(0, 3) == 0), fr);
            load_and_check(fr, $urandom_range(0, 1) == 1, "rand");
        end

        // Reset in the middle of a load abandons it.
        pulse_start();
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state",      64'(state_dbg),      64'(ST_IDLE));
        check("abort_core_reset", {63'd0, core_reset}, 64'd1);
        check("abort_busy",       {63'd0, busy},       64'd0);
        build_frame(1, 1'b0, fr);
        load_and_check(fr, 1'b0, "after_abort");

        // start during DATA is ignored.
        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        pulse_start();
        check("start_in_data", 64'(state_dbg), 64'(ST_DATA));
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'h01 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1'b0);
        check("data_start_done",  {63'd0, done}, 64'd1);
        check("data_start_write", 64'(wr_q.size() > 0 ? wr_q[0] : '0), 64'({6'd0, 32'hAABBCCDD}));

        // start in DONE re-arms the core reset the next cycle.
        pulse_start();
        check("done_start_core_reset", {63'd0, core_reset}, 64'd1);
        check("done_start_state",      64'(state_dbg),      64'(ST_COUNT));

        // reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("reset_beats_start", 64'(state_dbg), 64'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
